regfile_mp: RTL

- Parametrised successor of the CPU's three-ported register file: configurable width, depth, read-port count and write-port count.
- Adds a per-register busy scoreboard for multicycle/overlapped writeback.
- Adds a hardware init sweep after reset that zeroes every entry, with a ready flag.
- Sits between decode (read addresses, reserve) and writeback (write ports) in the multicycle datapath.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_sb.sv | 69 ++++++
 rtl/regfile_mp.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and state type for the multiported register file.
// Holds default XLEN/NREGS/NRP/NWP and the INIT/RUN state enum.
package regfile_mp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRP_DEF   = 2;
    localparam int NWP_DEF   = 1;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: per-register busy scoreboard with read-port busy lookup.
// Ports: clk, reset (sync, active high), run, we/wa (write clears),
//   rsv_en/rsv_addr (reserve sets), ra (read addrs), rd_busy (per read port).
// Optional REGFILE_MP_BYPASS_EN: a same-cycle write to a read address masks its busy bit.
module regfile_mp_sb
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = NRP_DEF,
    parameter int NWP   = NWP_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [NWP-1:0]    we,
    input  logic [NWP*AW-1:0] wa,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the reserve, so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int k = 0; k < NWP; k++) begin
                if (we[k]) begin
                    busy_d[wa[k*AW +: AW]] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != '0) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            if (run && ra[i*AW +: AW] != '0) begin
                rd_busy[i] = busy_q[ra[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
                // The forwarded value is the producer's result, so the
                // register is no longer pending unless re-reserved now.
                for (int k = 0; k < NWP; k++) begin
                    if (we[k] && wa[k*AW +: AW] == ra[i*AW +: AW]
                        && !(rsv_en && rsv_addr == ra[i*AW +: AW])) begin
                        rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multiport register file with init sweep and busy scoreboard.
// Ports: clk, reset (sync, active high), ready, we/wa/wd (write ports),
//   ra/rd/rd_busy (combinational read ports), rsv_en/rsv_addr (reserve).
// Optional REGFILE_MP_BYPASS_EN: same-cycle write data forwarded to read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = NRP_DEF,
    parameter int NWP   = NWP_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   wa,
    input  logic [NWP*XLEN-1:0] wd,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rd,
    output logic [NRP-1:0]      rd_busy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic            run;

    assign run   = (state_q == RUN);
    assign ready = run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rf_d    = rf_q;
        if (state_q == INIT) begin
            rf_d[cnt_q] = '0;
            cnt_d       = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end
        end else begin
            // Ascending order lets the highest port win a collision.
            for (int k = 0; k < NWP; k++) begin
                if (we[k] && wa[k*AW +: AW] != '0) begin
                    rf_d[wa[k*AW +: AW]] = wd[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRP; i++) begin
            if (run && ra[i*AW +: AW] != '0) begin
                rd[i*XLEN +: XLEN] = rf_q[ra[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int k = 0; k < NWP; k++) begin
                    if (we[k] && wa[k*AW +: AW] == ra[i*AW +: AW]) begin
                        rd[i*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    regfile_mp_sb #(
        .NREGS (NREGS),
        .NRP   (NRP),
        .NWP   (NWP),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .ra       (ra),
        .rd_busy  (rd_busy)
    );

endmodule
